// File: rtl/jcpu_pkg.sv
// Shared constants for the 8-bit CPU control section: opcodes, ALU codes,
// flag bit positions and one-hot step indices.
package jcpu_pkg;

  localparam int ALU_BIT = 7;

  localparam logic [3:0] OP_LD    = 4'h0;
  localparam logic [3:0] OP_ST    = 4'h1;
  localparam logic [3:0] OP_DATA  = 4'h2;
  localparam logic [3:0] OP_JMPR  = 4'h3;
  localparam logic [3:0] OP_JMP   = 4'h4;
  localparam logic [3:0] OP_JCOND = 4'h5;
  localparam logic [3:0] OP_CLF   = 4'h6;
  localparam logic [3:0] OP_IO    = 4'h7;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  // flags = {C,A,E,Z}
  localparam int FL_C = 3;
  localparam int FL_A = 2;
  localparam int FL_E = 1;
  localparam int FL_Z = 0;

  // step is declared [0:5], so index 0 is step 1
  localparam int S1 = 0;
  localparam int S2 = 1;
  localparam int S3 = 2;
  localparam int S4 = 3;
  localparam int S5 = 4;
  localparam int S6 = 5;

  function automatic logic [0:5] step_next(input logic [0:5] s);
    return {s[5], s[0:4]};
  endfunction

endpackage

// File: rtl/jstep_monitor.sv
// Watches the one-hot step stream for skips, multi-hot or stalled (all-zero)
// samples and counts completed instructions (step 6 -> step 1 transitions).
module jstep_monitor
  import jcpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ZERO_MAX = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:5]       step,
  output logic             seq_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int            ZW   = $clog2(ZERO_MAX + 2);
  localparam logic [ZW-1:0] ZMAX = ZW'(ZERO_MAX);

  logic [0:5]    prev;
  logic [ZW-1:0] zero_run;
  logic          legal;

  assign legal = (step == prev) || (step == step_next(prev));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev      <= 6'b100000;
      zero_run  <= '0;
      seq_err   <= 1'b0;
      instr_cnt <= '0;
    end else if (step == 6'b000000) begin
      if (zero_run >= ZMAX) seq_err <= 1'b1;
      // saturate one past the limit so the counter never wraps back to legal
      if (zero_run <= ZMAX) zero_run <= zero_run + 1'b1;
    end else begin
      zero_run <= '0;
      if (!legal) seq_err <= 1'b1;
      if ($onehot(step)) begin
        prev <= step;
        if (prev[S6] && step[S1]) instr_cnt <= instr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jcontrol.sv
// CPU control section: combinational step/instruction decode into bus enables
// and set strobes, plus the step-protocol monitor. JCPU_IO_EN adds the IO port.
module jcontrol
  import jcpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int ZERO_MAX = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clke,
  input  logic             clks,
  input  logic [0:5]       step,
  input  logic [7:0]       ir,
  input  logic [3:0]       flags,
  output logic             e_ram,
  output logic             e_acc,
  output logic             e_iar,
  output logic             bus1,
  output logic [3:0]       e_reg,
  output logic             s_mar,
  output logic             s_ram,
  output logic             s_acc,
  output logic             s_tmp,
  output logic             s_iar,
  output logic             s_ir,
  output logic             s_flags,
  output logic [3:0]       s_reg,
  output logic [2:0]       alu_op,
  output logic             seq_err,
  output logic [CNT_W-1:0] instr_cnt
`ifdef JCPU_IO_EN
  ,
  output logic             io_out,
  output logic             io_da,
  output logic             io_clke,
  output logic             io_clks
`endif
);

  logic       r_bus1, r_eram, r_eacc, r_eiar;
  logic       r_smar, r_sram, r_sacc, r_stmp, r_siar, r_sir, r_sflags;
  logic [3:0] r_ereg, r_sreg, ra_oh, rb_oh;
  logic [2:0] r_alu;
  logic       cond, en_ok, set_ok;

  assign ra_oh = 4'b0001 << ir[3:2];
  assign rb_oh = 4'b0001 << ir[1:0];
  assign cond  = (ir[3] & flags[FL_C]) | (ir[2] & flags[FL_A]) |
                 (ir[1] & flags[FL_E]) | (ir[0] & flags[FL_Z]);

  always_comb begin
    {r_bus1, r_eram, r_eacc, r_eiar} = '0;
    {r_smar, r_sram, r_sacc, r_stmp, r_siar, r_sir, r_sflags} = '0;
    r_ereg = '0;
    r_sreg = '0;
    r_alu  = '0;
    if (step[S1]) begin r_bus1 = 1'b1; r_eiar = 1'b1; r_smar = 1'b1; r_sacc = 1'b1; end
    if (step[S2]) begin r_eram = 1'b1; r_sir = 1'b1; end
    if (step[S3]) begin r_eacc = 1'b1; r_siar = 1'b1; end
    if (ir[ALU_BIT]) begin
      if (step[S4]) begin r_ereg |= rb_oh; r_stmp = 1'b1; end
      if (step[S5]) begin
        r_ereg |= ra_oh; r_alu = ir[6:4]; r_sacc = 1'b1; r_sflags = 1'b1;
      end
      if (step[S6]) begin
        r_eacc = 1'b1;
        if (ir[6:4] != ALU_CMP) r_sreg |= rb_oh;
      end
    end else begin
      case (ir[7:4])
        OP_LD: begin
          if (step[S4]) begin r_ereg |= ra_oh; r_smar = 1'b1; end
          if (step[S5]) begin r_eram = 1'b1; r_sreg |= rb_oh; end
        end
        OP_ST: begin
          if (step[S4]) begin r_ereg |= ra_oh; r_smar = 1'b1; end
          if (step[S5]) begin r_ereg |= rb_oh; r_sram = 1'b1; end
        end
        OP_DATA: begin
          if (step[S4]) begin r_bus1 = 1'b1; r_eiar = 1'b1; r_smar = 1'b1; r_sacc = 1'b1; end
          if (step[S5]) begin r_eram = 1'b1; r_sreg |= rb_oh; end
          if (step[S6]) begin r_eacc = 1'b1; r_siar = 1'b1; end
        end
        OP_JMPR: if (step[S4]) begin r_ereg |= rb_oh; r_siar = 1'b1; end
        OP_JMP: begin
          if (step[S4]) begin r_eiar = 1'b1; r_smar = 1'b1; end
          if (step[S5]) begin r_eram = 1'b1; r_siar = 1'b1; end
        end
        OP_JCOND: begin
          if (step[S4]) begin r_bus1 = 1'b1; r_eiar = 1'b1; r_smar = 1'b1; r_sacc = 1'b1; end
          if (step[S5]) begin r_eacc = 1'b1; r_siar = 1'b1; end
          if (step[S6]) begin r_eram = 1'b1; r_siar = cond; end
        end
        OP_CLF: if (step[S4]) begin r_bus1 = 1'b1; r_sflags = 1'b1; end
`ifdef JCPU_IO_EN
        OP_IO: begin
          if (ir[3] && step[S4])  r_ereg |= rb_oh;
          if (!ir[3] && step[S5]) r_sreg |= rb_oh;
        end
`endif
        default: ;
      endcase
    end
  end

  // reset gates the phases directly so strobes drop without a clock edge
  assign en_ok  = clke & ~reset;
  assign set_ok = clks & ~reset;

  assign bus1    = r_bus1 & en_ok;
  assign e_ram   = r_eram & en_ok;
  assign e_acc   = r_eacc & en_ok;
  assign e_iar   = r_eiar & en_ok;
  assign e_reg   = r_ereg & {4{en_ok}};
  assign s_mar   = r_smar & set_ok;
  assign s_ram   = r_sram & set_ok;
  assign s_acc   = r_sacc & set_ok;
  assign s_tmp   = r_stmp & set_ok;
  assign s_iar   = r_siar & set_ok;
  assign s_ir    = r_sir & set_ok;
  assign s_flags = r_sflags & set_ok;
  assign s_reg   = r_sreg & {4{set_ok}};
  assign alu_op  = reset ? 3'b000 : r_alu;

`ifdef JCPU_IO_EN
  logic io_act;
  assign io_act  = ~reset & (ir[7:4] == OP_IO) & (step[S4] | step[S5]);
  assign io_out  = io_act & ir[3];
  assign io_da   = io_act & ir[2];
  assign io_clks = io_act & ir[3] & step[S4] & clks;
  assign io_clke = io_act & ~ir[3] & step[S5] & clke;
`endif

  jstep_monitor #(.CNT_W(CNT_W), .ZERO_MAX(ZERO_MAX)) u_mon (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .seq_err   (seq_err),
    .instr_cnt (instr_cnt)
  );

endmodule

// File: tb/tb_jcontrol.sv
// Self-checking bench for jcontrol (default build, JCPU_IO_EN undefined):
// directed scenarios plus randomized instructions against a behavioural model.
module tb_jcontrol;

  localparam int CNT_W    = 16;
  localparam int ZERO_MAX = 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1, clke = 1'b0, clks = 1'b0;
  logic [0:5]       step = '0;
  logic [7:0]       ir = '0;
  logic [3:0]       flags = '0;
  logic             e_ram, e_acc, e_iar, bus1;
  logic             s_mar, s_ram, s_acc, s_tmp, s_iar, s_ir, s_flags;
  logic [3:0]       e_reg, s_reg;
  logic [2:0]       alu_op;
  logic             seq_err;
  logic [CNT_W-1:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // monitor model: step numbers 1..6, plain counts
  int               m_prev = 1;
  int               m_zero = 0;
  logic             m_err = 1'b0;
  logic [CNT_W-1:0] m_cnt = '0;

  // observed decode per step (1..6) and phase (0 = clke, 1 = clks)
  logic [21:0] hist [1:6][0:1];

  jcontrol #(.CNT_W(CNT_W), .ZERO_MAX(ZERO_MAX)) dut (
    .clk(clk), .reset(reset), .clke(clke), .clks(clks), .step(step), .ir(ir),
    .flags(flags), .e_ram(e_ram), .e_acc(e_acc), .e_iar(e_iar), .bus1(bus1),
    .e_reg(e_reg), .s_mar(s_mar), .s_ram(s_ram), .s_acc(s_acc), .s_tmp(s_tmp),
    .s_iar(s_iar), .s_ir(s_ir), .s_flags(s_flags), .s_reg(s_reg),
    .alu_op(alu_op), .seq_err(seq_err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // layout: bus1 e_ram e_acc e_iar e_reg[3:0] s_mar s_ram s_acc s_tmp s_iar s_ir s_flags s_reg[3:0] alu_op[2:0]
  function automatic logic [21:0] obs_dec();
    return {bus1, e_ram, e_acc, e_iar, e_reg, s_mar, s_ram, s_acc, s_tmp,
            s_iar, s_ir, s_flags, s_reg, alu_op};
  endfunction

  function automatic logic [0:5] stepv(input int n);
    logic [0:5] v;
    v = '0;
    if (n >= 1 && n <= 6) v[n-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [21:0] exp_dec(input int sn, input logic [7:0] i,
      input logic [3:0] f, input logic ce, input logic cs, input logic rst);
    logic b1, er, ea, ei, sm, sr, sa, st, si, sir, sf;
    logic [3:0] eg, sg, ga, gb;
    logic [2:0] al;
    {b1, er, ea, ei, sm, sr, sa, st, si, sir, sf} = '0;
    eg = '0; sg = '0; al = '0;
    ga = 4'b0001 << i[3:2];
    gb = 4'b0001 << i[1:0];
    if (sn == 1) begin b1 = 1; ei = 1; sm = 1; sa = 1; end
    else if (sn == 2) begin er = 1; sir = 1; end
    else if (sn == 3) begin ea = 1; si = 1; end
    else if (i[7]) begin
      if (sn == 4) begin eg = gb; st = 1; end
      if (sn == 5) begin eg = ga; al = i[6:4]; sa = 1; sf = 1; end
      if (sn == 6) begin ea = 1; if (i[6:4] != 3'd7) sg = gb; end
    end else begin
      case (i[6:4])
        3'd0: if (sn == 4) begin eg = ga; sm = 1; end
              else if (sn == 5) begin er = 1; sg = gb; end
        3'd1: if (sn == 4) begin eg = ga; sm = 1; end
              else if (sn == 5) begin eg = gb; sr = 1; end
        3'd2: if (sn == 4) begin b1 = 1; ei = 1; sm = 1; sa = 1; end
              else if (sn == 5) begin er = 1; sg = gb; end
              else if (sn == 6) begin ea = 1; si = 1; end
        3'd3: if (sn == 4) begin eg = gb; si = 1; end
        3'd4: if (sn == 4) begin ei = 1; sm = 1; end
              else if (sn == 5) begin er = 1; si = 1; end
        3'd5: if (sn == 4) begin b1 = 1; ei = 1; sm = 1; sa = 1; end
              else if (sn == 5) begin ea = 1; si = 1; end
              else if (sn == 6) begin er = 1; si = |(i[3:0] & f); end
        3'd6: if (sn == 4) begin b1 = 1; sf = 1; end
        default: ;
      endcase
    end
    if (rst) return '0;
    return {b1 & ce, er & ce, ea & ce, ei & ce, eg & {4{ce}}, sm & cs, sr & cs,
            sa & cs, st & cs, si & cs, sir & cs, sf & cs, sg & {4{cs}}, al};
  endfunction

  task automatic m_init();
    m_prev = 1; m_zero = 0; m_err = 1'b0; m_cnt = '0;
  endtask

  task automatic m_tick();
    int ones;
    int idx;
    ones = $countones(step);
    idx = 0;
    if (reset) begin m_init(); return; end
    if (ones == 0) begin
      m_zero++;
      if (m_zero > ZERO_MAX) m_err = 1'b1;
    end else begin
      m_zero = 0;
      if (ones > 1) m_err = 1'b1;
      else begin
        for (int k = 0; k < 6; k++) if (step[k]) idx = k + 1;
        if (idx != m_prev && idx != (m_prev % 6) + 1) m_err = 1'b1;
        if (m_prev == 6 && idx == 1) m_cnt++;
        m_prev = idx;
      end
    end
  endtask

  task automatic apply(input int sn, input logic [7:0] i, input logic [3:0] f,
                       input logic ce, input logic cs);
    @(negedge clk);
    step = stepv(sn); ir = i; flags = f; clke = ce; clks = cs;
    #1;
  endtask

  task automatic edge_tick();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clke = 1'b0; clks = 1'b0; step = stepv(1);
    m_init();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    edge_tick();
  endtask

  task automatic run_instr(input logic [7:0] i, input logic [3:0] f, input bit rnd);
    logic ce, cs;
    for (int sn = 1; sn <= 6; sn++) begin
      for (int ph = 0; ph < 2; ph++) begin
        ce = rnd ? 1'($urandom_range(0, 1)) : (ph == 0);
        cs = rnd ? 1'($urandom_range(0, 1)) : (ph == 1);
        apply(sn, i, f, ce, cs);
        hist[sn][ph] = obs_dec();
        n_cmp++;
        if (hist[sn][ph] !== exp_dec(sn, i, f, ce, cs, reset)) begin
          n_bad++;
          $display("FAIL decode ir=%h flags=%b step=%0d ce=%0b cs=%0b got=%h want=%h",
                   i, f, sn, ce, cs, hist[sn][ph], exp_dec(sn, i, f, ce, cs, reset));
        end
        edge_tick();
        n_cmp++;
        if ({seq_err, instr_cnt} !== {m_err, m_cnt}) begin
          n_bad++;
          $display("FAIL monitor step=%0d got err=%0b cnt=%0d want err=%0b cnt=%0d",
                   sn, seq_err, instr_cnt, m_err, m_cnt);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; step = stepv(3); ir = 8'($urandom); clke = 1'b1; clks = 1'b1;
    m_init();
    #1;
    n_cmp++;
    if (obs_dec() !== 22'd0) begin
      n_bad++; $display("FAIL reset_decode got=%h want=0", obs_dec());
    end
    n_cmp++;
    if (seq_err !== 1'b0 || instr_cnt !== '0) begin
      n_bad++; $display("FAIL reset_monitor got err=%0b cnt=%0d want 0/0", seq_err, instr_cnt);
    end
    do_reset();
  endtask

  task automatic test_ld();
    run_instr(8'h00, 4'($urandom), 1'b0);
    n_cmp++;
    if (hist[1][0][21] !== 1'b1 || hist[1][0][18] !== 1'b1 ||
        hist[1][1][13] !== 1'b1 || hist[1][1][11] !== 1'b1) begin
      n_bad++; $display("FAIL ld_s1 got=%h/%h want bus1,e_iar,s_mar,s_acc", hist[1][0], hist[1][1]);
    end
    n_cmp++;
    if (hist[5][0][20] !== 1'b1 || hist[5][1][6:3] !== 4'b0001 || hist[5][0][6:3] !== 4'b0000) begin
      n_bad++; $display("FAIL ld_s5 got=%h/%h want e_ram, s_reg=0001 on clks only", hist[5][0], hist[5][1]);
    end
    apply(1, 8'h00, 4'h0, 1'b1, 1'b0);
    edge_tick();
    n_cmp++;
    if (instr_cnt !== 16'd1 || m_cnt !== 16'd1) begin
      n_bad++; $display("FAIL ld_count got=%0d want 1", instr_cnt);
    end
  endtask

  task automatic test_alu();
    run_instr(8'h86, 4'($urandom), 1'b0);
    n_cmp++;
    if (hist[4][0][17:14] !== 4'b0100 || hist[4][1][10] !== 1'b1) begin
      n_bad++; $display("FAIL add_s4 got=%h/%h want e_reg=0100 s_tmp", hist[4][0], hist[4][1]);
    end
    n_cmp++;
    if (hist[5][0][17:14] !== 4'b0010 || hist[5][0][2:0] !== 3'b000 ||
        hist[5][1][11] !== 1'b1 || hist[5][1][7] !== 1'b1) begin
      n_bad++; $display("FAIL add_s5 got=%h/%h want e_reg=0010 alu=000 s_acc s_flags", hist[5][0], hist[5][1]);
    end
    n_cmp++;
    if (hist[6][1][6:3] !== 4'b0100) begin
      n_bad++; $display("FAIL add_s6 got s_reg=%b want 0100", hist[6][1][6:3]);
    end
    run_instr(8'hF6, 4'($urandom), 1'b0);
    n_cmp++;
    if (hist[6][1][6:3] !== 4'b0000 || hist[6][0][19] !== 1'b1 || hist[5][0][2:0] !== 3'b111) begin
      n_bad++; $display("FAIL cmp_s6 got=%h/%h want no s_reg, e_acc, alu=111", hist[6][0], hist[6][1]);
    end
  endtask

  task automatic test_jcond();
    run_instr(8'h58, 4'b1000, 1'b0);
    n_cmp++;
    if (hist[6][1][9] !== 1'b1) begin
      n_bad++; $display("FAIL jcond_taken got s_iar=%b want 1", hist[6][1][9]);
    end
    run_instr(8'h58, 4'b0111, 1'b0);
    n_cmp++;
    if (hist[6][1][9] !== 1'b0) begin
      n_bad++; $display("FAIL jcond_not_taken got s_iar=%b want 0", hist[6][1][9]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) run_instr(8'($urandom), 4'($urandom), 1'b1);
  endtask

  task automatic test_skip();
    int seq[6] = '{1, 2, 4, 5, 6, 1};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(seq[k], 8'($urandom), 4'h0, 1'b0, 1'b0);
      edge_tick();
      n_cmp++;
      if (seq_err !== (k >= 2) || seq_err !== m_err) begin
        n_bad++; $display("FAIL skip_err idx=%0d got=%0b want=%0b", k, seq_err, (k >= 2));
      end
    end
    do_reset();
    n_cmp++;
    if (seq_err !== 1'b0 || instr_cnt !== '0) begin
      n_bad++; $display("FAIL skip_reset got err=%0b cnt=%0d want 0/0", seq_err, instr_cnt);
    end
  endtask

  task automatic test_zero();
    int seq[5] = '{1, 0, 2, 0, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(seq[k], 8'h00, 4'h0, 1'b1, 1'b1);
      edge_tick();
      n_cmp++;
      if (seq_err !== (k == 4) || seq_err !== m_err) begin
        n_bad++; $display("FAIL zero_run idx=%0d got=%0b want=%0b", k, seq_err, (k == 4));
      end
    end
  endtask

  task automatic test_async();
    do_reset();
    for (int sn = 1; sn <= 4; sn++) begin
      apply(sn, 8'h00, 4'h0, 1'b1, 1'b0);
      edge_tick();
    end
    apply(5, 8'h00, 4'h0, 1'b0, 1'b1);
    n_cmp++;
    if (s_reg !== 4'b0001) begin
      n_bad++; $display("FAIL async_pre got s_reg=%b want 0001", s_reg);
    end
    #1 reset = 1'b1;
    m_init();
    #1;
    n_cmp++;
    if (obs_dec() !== 22'd0 || seq_err !== 1'b0) begin
      n_bad++; $display("FAIL async_drop got=%h err=%0b want 0/0", obs_dec(), seq_err);
    end
    step = stepv(1);
    @(negedge clk);
    reset = 1'b0;
    edge_tick();
    run_instr(8'($urandom), 4'($urandom), 1'b1);
    n_cmp++;
    if (seq_err !== 1'b0) begin
      n_bad++; $display("FAIL async_restart got err=%0b want 0", seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_alu();
    test_jcond();
    test_random();
    test_skip();
    test_zero();
    test_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
